// File: rtl/collision_pkg.sv
// Shared definitions for the collision scanner slice.
//   - DIR_*        : bit positions inside the 4-bit contact/direction vector
//   - HALF_W_DEF   : default width of one coordinate/size half
//   - COIN_TYPE_DEF: default object type code that produces coin events
//   - xy_t         : packed {x, y} (or {w, h}) word at the default width
//   - scan_state_t : scanner FSM states
//   - count_ones   : population count helper for masks up to 64 bits
package collision_pkg;

    localparam int DIR_RIGHT = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_UP    = 3;

    localparam int unsigned HALF_W_DEF    = 16;
    localparam int unsigned COIN_TYPE_DEF = 102;

    typedef struct packed {
        logic [HALF_W_DEF-1:0] x;
        logic [HALF_W_DEF-1:0] y;
    } xy_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    function automatic logic [6:0] count_ones(input logic [63:0] v);
        logic [6:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/collision_pair_eval.sv
// Combinational overlap and contact-direction test for one self/object pair.
// Ports:
//   self_coord, self_size   : {x, y} and {w, h} of the player
//   other_coord, other_size : {x, y} and {w, h} of the candidate object
//   hit                     : boxes overlap (touching edges and zero-size boxes excluded)
//   dir                     : one-hot contact direction when hit, else 0
module collision_pair_eval
    import collision_pkg::*;
#(
    parameter int unsigned HALF_W = HALF_W_DEF
) (
    input  logic [2*HALF_W-1:0] self_coord,
    input  logic [2*HALF_W-1:0] self_size,
    input  logic [2*HALF_W-1:0] other_coord,
    input  logic [2*HALF_W-1:0] other_size,
    output logic                hit,
    output logic [3:0]          dir
);

    // One extra bit so that position + size never wraps.
    logic [HALF_W:0] sx, sy, sw, sh, ox, oy, ow, oh;
    logic [HALF_W:0] sx_end, sy_end, ox_end, oy_end;
    logic [HALF_W:0] lo_x, hi_x, lo_y, hi_y, ovx, ovy;
    logic            zero_size;

    always_comb begin
        sx = {1'b0, self_coord[2*HALF_W-1:HALF_W]};
        sy = {1'b0, self_coord[HALF_W-1:0]};
        sw = {1'b0, self_size[2*HALF_W-1:HALF_W]};
        sh = {1'b0, self_size[HALF_W-1:0]};
        ox = {1'b0, other_coord[2*HALF_W-1:HALF_W]};
        oy = {1'b0, other_coord[HALF_W-1:0]};
        ow = {1'b0, other_size[2*HALF_W-1:HALF_W]};
        oh = {1'b0, other_size[HALF_W-1:0]};

        sx_end = sx + sw;
        sy_end = sy + sh;
        ox_end = ox + ow;
        oy_end = oy + oh;

        // A zero-width/height box would otherwise pass the strict
        // inequalities when it lies strictly inside the other box.
        zero_size = (sw == '0) || (sh == '0) || (ow == '0) || (oh == '0);

        hit = !zero_size && (sx < ox_end) && (ox < sx_end)
                         && (sy < oy_end) && (oy < sy_end);

        hi_x = (sx_end < ox_end) ? sx_end : ox_end;
        lo_x = (sx > ox) ? sx : ox;
        hi_y = (sy_end < oy_end) ? sy_end : oy_end;
        lo_y = (sy > oy) ? sy : oy;
        ovx  = hi_x - lo_x;
        ovy  = hi_y - lo_y;

        // The shallower penetration axis decides the contact side; ties go horizontal.
        dir = '0;
        if (hit) begin
            if (ovx <= ovy) begin
                if (ox >= sx) dir[DIR_RIGHT] = 1'b1;
                else          dir[DIR_LEFT]  = 1'b1;
            end else begin
                if (oy >= sy) dir[DIR_DOWN]  = 1'b1;
                else          dir[DIR_UP]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/collision_scanner.sv
// Time-multiplexed collision aggregator: one shared pair evaluator walks
// N_OBJ objects, one per clock, after each accepted frame start.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : frame tick, accepted only when idle
//   self_coord/size     : player box, latched on accepted start
//   other_coord/size    : packed object boxes, object i at [i*2*HALF_W +: 2*HALF_W]
//   coll_enable         : per-object enable
//   type_list           : packed object type codes
//   busy                : scan in progress (SCAN and DONE states)
//   done                : one-cycle pulse when results update
//   collision           : OR of contact directions, [0]R [1]L [2]D [3]U
//   hit_mask            : per-object hit result of last scan
//   coin_pulse          : pulse with done when new coin contacts exist
//   coin_count          : number of new coin contacts
//   overrun             : sticky, start seen while busy
module collision_scanner
    import collision_pkg::*;
#(
    parameter  int unsigned N_OBJ     = 20,
    parameter  int unsigned HALF_W    = HALF_W_DEF,
    parameter  int unsigned TYPE_W    = 10,
    parameter  int unsigned COIN_TYPE = COIN_TYPE_DEF,
    localparam int unsigned IDX_W     = $clog2(N_OBJ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [2*HALF_W-1:0]        self_coord,
    input  logic [2*HALF_W-1:0]        self_size,
    input  logic [N_OBJ*2*HALF_W-1:0]  other_coord,
    input  logic [N_OBJ*2*HALF_W-1:0]  other_size,
    input  logic [N_OBJ-1:0]           coll_enable,
    input  logic [N_OBJ*TYPE_W-1:0]    type_list,
    output logic                       busy,
    output logic                       done,
    output logic [3:0]                 collision,
    output logic [N_OBJ-1:0]           hit_mask,
    output logic                       coin_pulse,
    output logic [IDX_W:0]             coin_count,
    output logic                       overrun
);

    scan_state_t         state, state_next;
    logic [IDX_W-1:0]    idx;
    logic [2*HALF_W-1:0] self_coord_q, self_size_q;
    logic [2*HALF_W-1:0] obj_coord, obj_size;
    logic [TYPE_W-1:0]   obj_type;
    logic                obj_overlap, obj_hit, obj_coin, last_obj;
    logic [3:0]          obj_dir;
    logic [3:0]          coll_acc;
    logic [N_OBJ-1:0]    hit_acc, coin_acc, coin_prev, coin_new;

    always_comb begin
        obj_coord = other_coord[int'(idx)*2*HALF_W +: 2*HALF_W];
        obj_size  = other_size[int'(idx)*2*HALF_W +: 2*HALF_W];
        obj_type  = type_list[int'(idx)*TYPE_W +: TYPE_W];
        obj_hit   = obj_overlap && coll_enable[idx];
        obj_coin  = obj_hit && (obj_type == TYPE_W'(COIN_TYPE));
        last_obj  = (idx == IDX_W'(N_OBJ - 1));
        coin_new  = coin_acc & ~coin_prev;
    end

    collision_pair_eval #(
        .HALF_W (HALF_W)
    ) u_pair_eval (
        .self_coord  (self_coord_q),
        .self_size   (self_size_q),
        .other_coord (obj_coord),
        .other_size  (obj_size),
        .hit         (obj_overlap),
        .dir         (obj_dir)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (start)    state_next = ST_SCAN;
            ST_SCAN: if (last_obj) state_next = ST_DONE;
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx          <= '0;
            self_coord_q <= '0;
            self_size_q  <= '0;
            coll_acc     <= '0;
            hit_acc      <= '0;
            coin_acc     <= '0;
            coin_prev    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            collision    <= '0;
            hit_mask     <= '0;
            coin_pulse   <= 1'b0;
            coin_count   <= '0;
            overrun      <= 1'b0;
        end else begin
            busy       <= (state_next != ST_IDLE);
            done       <= 1'b0;
            coin_pulse <= 1'b0;
            if (start && state != ST_IDLE) overrun <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        self_coord_q <= self_coord;
                        self_size_q  <= self_size;
                        idx          <= '0;
                        coll_acc     <= '0;
                        hit_acc      <= '0;
                        coin_acc     <= '0;
                    end
                end
                ST_SCAN: begin
                    hit_acc[idx]  <= obj_hit;
                    coin_acc[idx] <= obj_coin;
                    coll_acc      <= coll_acc | (obj_hit ? obj_dir : 4'b0000);
                    idx           <= idx + 1'b1;
                end
                ST_DONE: begin
                    collision  <= coll_acc;
                    hit_mask   <= hit_acc;
                    coin_count <= (IDX_W+1)'(count_ones(64'(coin_new)));
                    coin_pulse <= |coin_new;
                    coin_prev  <= coin_acc;
                    done       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scanner.sv
// Self-checking bench for collision_scanner: table of scan scenarios plus
// hand-written overrun, continuous-start and mid-scan reset sequences.
module tb_collision_scanner;
    import collision_pkg::*;

    localparam int unsigned N  = 20;
    localparam int unsigned HW = 16;
    localparam int unsigned TW = 10;
    localparam int unsigned CW = $clog2(N) + 1;
    localparam int unsigned NV = 15;

    logic              clk = 1'b0;
    logic              rst_n, start;
    logic [2*HW-1:0]   self_coord, self_size;
    logic [N*2*HW-1:0] other_coord, other_size;
    logic [N-1:0]      coll_enable;
    logic [N*TW-1:0]   type_list;
    logic              busy, done, coin_pulse, overrun;
    logic [3:0]        collision;
    logic [N-1:0]      hit_mask;
    logic [CW-1:0]     coin_count;

    collision_scanner #(
        .N_OBJ     (N),
        .HALF_W    (HW),
        .TYPE_W    (TW),
        .COIN_TYPE (102)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .self_coord  (self_coord),
        .self_size   (self_size),
        .other_coord (other_coord),
        .other_size  (other_size),
        .coll_enable (coll_enable),
        .type_list   (type_list),
        .busy        (busy),
        .done        (done),
        .collision   (collision),
        .hit_mask    (hit_mask),
        .coin_pulse  (coin_pulse),
        .coin_count  (coin_count),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        v;
        logic [4:0]  idx;
        logic [15:0] x, y, w, h;
        logic        en;
        logic [9:0]  typ;
    } obj_t;

    typedef struct {
        logic [15:0]   sx, sy, sw, sh;
        obj_t          o0, o1, o2, o3;
        logic [3:0]    coll;
        logic [N-1:0]  mask;
        logic          pulse;
        logic [CW-1:0] cnt;
    } vec_t;

    typedef struct {
        logic [3:0]    coll;
        logic [N-1:0]  mask;
        logic          pulse;
        logic [CW-1:0] cnt;
        int            due;
    } exp_t;

    localparam obj_t NO = '0;

    vec_t tbl [NV];
    exp_t sb [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic obj_t mk(input int idx, input int x, input int y,
                                input int w, input int h, input bit en, input int typ);
        return {1'b1, 5'(idx), 16'(x), 16'(y), 16'(w), 16'(h), en, 10'(typ)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest pending scan.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done pulse with no scan pending (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                chk("collision",  32'(collision),  32'(mon_e.coll));
                chk("hit_mask",   32'(hit_mask),   32'(mon_e.mask));
                chk("coin_pulse", 32'(coin_pulse), 32'(mon_e.pulse));
                chk("coin_count", 32'(coin_count), 32'(mon_e.cnt));
                chk("done_cycle", cyc,             mon_e.due);
            end
        end
    end

    task automatic put_obj(input obj_t o);
        xy_t c, s;
        if (o.v) begin
            c.x = o.x; c.y = o.y;
            s.x = o.w; s.y = o.h;
            other_coord[int'(o.idx)*2*HW +: 2*HW] = c;
            other_size[int'(o.idx)*2*HW +: 2*HW]  = s;
            coll_enable[o.idx]                    = o.en;
            type_list[int'(o.idx)*TW +: TW]       = o.typ;
        end
    endtask

    task automatic load_vec(input vec_t v);
        @(negedge clk);
        self_coord  = {v.sx, v.sy};
        self_size   = {v.sw, v.sh};
        other_coord = '0;
        other_size  = '0;
        coll_enable = '0;
        type_list   = '0;
        put_obj(v.o0);
        put_obj(v.o1);
        put_obj(v.o2);
        put_obj(v.o3);
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL done_timeout: %0d scans still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_scan(input exp_t e);
        @(negedge clk);
        e.due = cyc + N + 2;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(N + 8);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   c0;

        // self (10,10,16,16) spans x/y 10..26 unless noted
        tbl[0]  = '{16'd10, 16'd10, 16'd16, 16'd16, mk(3, 20, 12, 16, 16, 1, 0), NO, NO, NO,
                    4'b0001, 20'h00008, 1'b0, 6'd0};
        tbl[1]  = '{16'd10, 16'd10, 16'd16, 16'd16, mk(0, 12, 0, 8, 12, 1, 0),
                    mk(1, 0, 14, 12, 8, 1, 0), mk(2, 14, 20, 8, 16, 0, 0), NO,
                    4'b1010, 20'h00003, 1'b0, 6'd0};
        tbl[2]  = '{16'd10, 16'd10, 16'd16, 16'd16, mk(5, 26, 10, 16, 16, 1, 0),
                    mk(6, 10, 26, 16, 16, 1, 0), mk(7, 26, 10, 16, 16, 1, 102), NO,
                    4'b0000, 20'h00000, 1'b0, 6'd0};
        tbl[3]  = '{16'd10, 16'd10, 16'd16, 16'd16, mk(4, 15, 15, 0, 8, 1, 0),
                    mk(5, 15, 15, 8, 0, 1, 0), NO, NO,
                    4'b0000, 20'h00000, 1'b0, 6'd0};
        tbl[4]  = '{16'd10, 16'd10, 16'd16, 16'd16, mk(9, 20, 20, 16, 16, 1, 0),
                    mk(10, 0, 0, 16, 16, 1, 0), NO, NO,
                    4'b0011, 20'h00600, 1'b0, 6'd0};
        tbl[5]  = '{16'd10, 16'd10, 16'd16, 16'd16, mk(11, 12, 20, 8, 16, 1, 0), NO, NO, NO,
                    4'b0100, 20'h00800, 1'b0, 6'd0};
        tbl[6]  = '{16'd10, 16'd10, 16'd16, 16'd16, mk(12, 0, 0, 100, 100, 1, 0), NO, NO, NO,
                    4'b0010, 20'h01000, 1'b0, 6'd0};
        tbl[7]  = '{16'hFFF0, 16'hFFF0, 16'h0020, 16'h0020, mk(13, 5, 5, 8, 8, 1, 0),
                    mk(14, 'hFFF8, 'hFFF8, 'h10, 'h10, 1, 0), NO, NO,
                    4'b0001, 20'h04000, 1'b0, 6'd0};
        tbl[8]  = '{16'd10, 16'd10, 16'd16, 16'd16, mk(7, 20, 12, 16, 16, 1, 102), NO, NO, NO,
                    4'b0001, 20'h00080, 1'b1, 6'd1};
        tbl[9]  = '{16'd10, 16'd10, 16'd16, 16'd16, mk(7, 20, 12, 16, 16, 1, 102), NO, NO, NO,
                    4'b0001, 20'h00080, 1'b0, 6'd0};
        tbl[10] = '{16'd10, 16'd10, 16'd16, 16'd16, mk(7, 20, 12, 16, 16, 1, 102), NO, NO, NO,
                    4'b0001, 20'h00080, 1'b0, 6'd0};
        tbl[11] = '{16'd10, 16'd10, 16'd16, 16'd16, mk(7, 20, 12, 16, 16, 0, 102), NO, NO, NO,
                    4'b0000, 20'h00000, 1'b0, 6'd0};
        tbl[12] = '{16'd10, 16'd10, 16'd16, 16'd16, mk(7, 20, 12, 16, 16, 1, 102), NO, NO, NO,
                    4'b0001, 20'h00080, 1'b1, 6'd1};
        tbl[13] = '{16'd10, 16'd10, 16'd16, 16'd16, mk(7, 20, 12, 16, 16, 1, 102),
                    mk(8, 0, 14, 12, 8, 1, 102), mk(15, 12, 0, 8, 12, 1, 102), NO,
                    4'b1011, 20'h08180, 1'b1, 6'd2};
        tbl[14] = '{16'd10, 16'd10, 16'd16, 16'd16, mk(7, 20, 12, 16, 16, 1, 102),
                    mk(8, 0, 14, 12, 8, 1, 102), mk(15, 12, 0, 8, 12, 1, 102),
                    mk(16, 14, 20, 8, 16, 0, 102),
                    4'b1011, 20'h08180, 1'b0, 6'd0};

        rst_n = 1'b0; start = 1'b0;
        self_coord = '0; self_size = '0;
        other_coord = '0; other_size = '0; coll_enable = '0; type_list = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",       32'(busy),       0);
        chk("rst_done",       32'(done),       0);
        chk("rst_collision",  32'(collision),  0);
        chk("rst_hit_mask",   32'(hit_mask),   0);
        chk("rst_coin_pulse", 32'(coin_pulse), 0);
        chk("rst_coin_count", 32'(coin_count), 0);
        chk("rst_overrun",    32'(overrun),    0);
        rst_n = 1'b1;

        for (int i = 0; i < int'(NV); i++) begin
            load_vec(tbl[i]);
            e.coll  = tbl[i].coll;
            e.mask  = tbl[i].mask;
            e.pulse = tbl[i].pulse;
            e.cnt   = tbl[i].cnt;
            e.due   = 0;
            run_scan(e);
        end
        chk("overrun_idle", 32'(overrun), 0);

        // Overrun: extra start while object 4 is being evaluated; same coin set stays in contact.
        e.coll = 4'b1011; e.mask = 20'h08180; e.pulse = 1'b0; e.cnt = '0;
        @(negedge clk);
        e.due = cyc + N + 2;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_scan", 32'(busy), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain(N + 8);
        chk("overrun_set", 32'(overrun), 1);
        chk("busy_idle",   32'(busy),    0);

        // Start held high: three scans, one every N+2 cycles.
        @(negedge clk);
        c0 = cyc;
        for (int k = 1; k <= 3; k++) begin
            e.due = c0 + k * int'(N + 2);
            sb.push_back(e);
        end
        start = 1'b1;
        while (cyc < c0 + 1 + 2 * int'(N + 2)) @(negedge clk);
        start = 1'b0;
        wait_drain(N + 8);
        chk("overrun_sticky", 32'(overrun), 1);

        // Reset while object 5 is being evaluated: the scan is abandoned.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_busy",       32'(busy),       0);
        chk("abort_collision",  32'(collision),  0);
        chk("abort_hit_mask",   32'(hit_mask),   0);
        chk("abort_coin_count", 32'(coin_count), 0);
        chk("abort_overrun",    32'(overrun),    0);
        repeat (N + 6) @(negedge clk);

        // Coin history was cleared, so all three coins count as new.
        e.coll = 4'b1011; e.mask = 20'h08180; e.pulse = 1'b1; e.cnt = 6'd3;
        run_scan(e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/collision_scanner.md
Name: collision_scanner

Overview:
- Parametrised, time-multiplexed successor to the flat 20-instance collision aggregator.
- One shared overlap/direction unit walks N_OBJ candidate objects, one per clock, after each frame start.
- Publishes aggregated 4-direction contact flags and a per-object hit mask.
- Emits an edge-detected coin event with a count of newly touched coins. Sits between the object table and the player physics / score logic.

Parameters:
- N_OBJ, 20, number of candidate objects scanned per frame (2..64).
- HALF_W, 16, width of each coordinate/size half; packed word is {x/w[2*HALF_W-1:HALF_W], y/h[HALF_W-1:0]}.
- TYPE_W, 10, width of each object type code.
- COIN_TYPE, 102, type code that generates coin events.
- IDX_W, $clog2(N_OBJ), scan index width (derived, localparam).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  frame tick; begins a scan when idle
- self_coord  in  2*HALF_W  player {x,y}, latched on accepted start
- self_size  in  2*HALF_W  player {w,h}, latched on accepted start
- other_coord  in  N_OBJ*2*HALF_W  packed object coordinates, object i at [i*2*HALF_W +: 2*HALF_W]
- other_size  in  N_OBJ*2*HALF_W  packed object sizes, same packing
- coll_enable  in  N_OBJ  per-object collision enable
- type_list  in  N_OBJ*TYPE_W  packed object types
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; results updated this cycle
- collision  out  4  [0]=right [1]=left [2]=down [3]=up, held until next done
- hit_mask  out  N_OBJ  per-object overlap result of last scan
- coin_pulse  out  1  one-cycle pulse coincident with done when ≥1 new coin contact
- coin_count  out  IDX_W+1  number of new coin contacts, held until next done
- overrun  out  1  sticky; start seen while busy

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, busy=0, done=0, collision=0, hit_mask=0, coin_pulse=0, coin_count=0, overrun=0, previous-coin mask=0, accumulators=0. Reset mid-scan aborts the scan with no done.
- FSM states:
  - IDLE: start=1 → latch self_coord/self_size, idx=0, clear accumulators, go SCAN.
  - SCAN: evaluate object idx each cycle; idx==N_OBJ-1 → go DONE, else idx+1.
  - DONE: single cycle, go IDLE.
- Latency: start accepted at edge T; objects evaluated at edges T+1..T+N_OBJ; done=1 in the cycle after edge T+N_OBJ+1. A new start is accepted in that DONE cycle, giving back-to-back throughput of N_OBJ+2 cycles.
- Other-object inputs are sampled at the edge their index is evaluated. The caller holds them stable while busy=1. Self values use the latched copy.
- busy=1 in SCAN and DONE.
- Overlap test, computed at HALF_W+1 bits unsigned with no wrap: sx<ox+ow && ox<sx+sw && sy<oy+oh && oy<sy+sh. Touching edges (equality) do not count as overlap. Zero-size objects never hit.
- hit(i) = overlap && coll_enable[i].
- Direction when hit:
  - Compute ovx = min(sx+sw, ox+ow) - max(sx, ox) and ovy likewise for y.
  - If ovx<=ovy, the contact is horizontal: right if ox>=sx, else left.
  - Otherwise the contact is vertical: down if oy>=sy, else up.
  - y grows downward. Exactly one direction bit per hit object.
- Accumulation: direction bits are OR-ed across all objects. Hit bits are written into a working mask.
- At the DONE transition, collision, hit_mask and coin_count are loaded and done pulses.
- Coin logic:
  - Working coin mask = hit(i) && type==COIN_TYPE.
  - new = coin & ~prev; coin_count = popcount(new); coin_pulse = |new.
  - prev is updated to coin at DONE. A coin held in contact over many frames produces exactly one pulse.
  - An object whose coin contact is lost then regained pulses again.
- start while busy is ignored and sets overrun. overrun clears only on reset.
- start held high continuously rescans every N_OBJ+2 cycles.
- Outputs are registered. No combinational path from inputs to outputs.

Decomposition:
- Shared package collision_pkg holds:
  - direction index constants DIR_RIGHT=0, DIR_LEFT=1, DIR_DOWN=2, DIR_UP=3;
  - the COIN_TYPE default;
  - HALF_W default;
  - a packed typedef for the {x,y} word.
- One natural sub-module: collision_pair_eval. It is purely combinational: self coord/size and other coord/size in, {hit, dir[3:0]} out. It is instantiated once and reused by the original aggregator's replacement flow.

Test Plan:
- Reset mid-scan: start, then rst_n=0 at idx=5 → no done, all outputs 0. The next start completes after N_OBJ+2 cycles.
- Single block right: self (10,10,16,16), obj3 (20,12,16,16) enabled, others disabled → collision=4'b0001, hit_mask=1<<3, done exactly N_OBJ+2 cycles after start.
- Mixed directions:
  - obj0 above (12,0,8,12) → collision bit3;
  - obj1 to the left (0,14,12,8) → collision bit1;
  - obj2 disabled overlapping below → ignored.
  - Expected collision=4'b1010.
- Edge touch: obj at x=sx+sw exactly → no hit, collision=0.
- Coin edge detect:
  - obj7 type 102 overlapping for 3 consecutive scans → coin_pulse only on the first, coin_count=1.
  - Remove for one scan, restore → pulse again.
  - Two new coins in the same scan → coin_count=2.
- Overrun: start asserted at idx=4 → scan continues unaffected and overrun=1 stays set. start held high → done every N_OBJ+2 cycles.
